id_alloc_ctrl: RTL and testbench
================================

Name: id_alloc_ctrl

Overview:
- Controller that sequences unique-ID allocation and release for the read reorder buffer.
- Accepts original AXI master IDs over a valid/ready channel and assigns each a {row, col} unique ID.
  - row: table slot bound to that master ID.
  - col: in-order sequence slot within the row.
- Holds the result in an output register until the downstream channel accepts it.
- Retires unique IDs when responses complete, freeing a row once its last outstanding entry drains.
- Sits between the AR ingress and the remapped AR issue path; the release port is driven by the ROB response side.

Parameters:
- ID_WIDTH, 4, width of the original master ID.
- MAX_OUTSTANDING, 16, number of rows and columns per row. Must be a power of 2, ≥2.
- IDX_W, $clog2(MAX_OUTSTANDING), derived local, not overridable.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  allocation request valid
- in_ready  out  1  allocation request accepted this cycle
- in_id  in  ID_WIDTH  original master ID
- out_valid  out  1  allocated unique ID valid
- out_ready  in  1  downstream accepts out_uid
- out_uid  out  2*IDX_W  {row, col}; row in the MSBs
- out_id  out  ID_WIDTH  original ID echoed with out_uid
- rel_valid  in  1  release one unique ID; always accepted
- rel_uid  in  2*IDX_W  unique ID being released
- full  out  1  no row has a free column and no row is unused
- err  out  1  sticky protocol error (see Optional Feature)

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values:
  - out_valid=0, out_uid=0, out_id=0, err=0, full=0, FSM=S_IDLE.
  - All rows: used=0, id=0, wr_col=0, cnt=0.
  - Reset mid-operation discards any held output and all outstanding state.
- Per-row state: used (1b), id (ID_WIDTH), wr_col (IDX_W, next column), cnt (IDX_W+1, outstanding count).
- Resource lookup (combinational, on in_id):
  - Match row: used && id==in_id. At most one row matches by construction.
  - If a match row exists, allocation is possible only when cnt<MAX_OUTSTANDING. A full match row stalls; a second row is never opened for the same ID, to preserve order.
  - If no match row exists, use the lowest-index row with used==0.
  - alloc_ok = a legal target row exists.
- FSM:
  - S_IDLE: output register empty. in_ready = alloc_ok.
    - in_valid && alloc_ok → S_OUT.
    - in_valid && !alloc_ok → S_STALL.
  - S_OUT: out_valid=1. in_ready = out_ready && alloc_ok.
    - out_ready with no new accept → S_IDLE.
    - out_ready with a new accept → stay in S_OUT (back-to-back, 1 result/cycle).
    - out_ready with in_valid && !alloc_ok → S_STALL.
  - S_STALL: in_ready=0 until alloc_ok, then accept → S_OUT.
    - in_valid dropping (illegal per AXI) → S_IDLE.
- Allocation on accept (cycle T):
  - out_uid <= {row, wr_col[row]} and out_id <= in_id, valid at T+1.
  - wr_col <= wr_col+1, wrapping mod MAX_OUTSTANDING.
  - cnt <= cnt+1.
  - For a new row: used <= 1, id <= in_id.
- Release:
  - On rel_valid, cnt[rel_uid row] <= cnt-1.
  - When the result is 0: used <= 0 and wr_col <= 0.
  - The column field of rel_uid is not checked against order; per-ID AXI ordering guarantees in-order retirement.
- Simultaneous allocate and release, same row:
  - Net cnt change is 0 and the row stays used.
  - Lookup uses pre-release state, so a row at cnt==MAX_OUTSTANDING is not allocatable in the same cycle as its release; it becomes allocatable next cycle.
- Simultaneous allocate to a free row and release of a different row: independent.
- full is registered from next-state: all rows used and every cnt==MAX_OUTSTANDING.

Optional Feature:
- Macro: ID_ALLOC_ERR_CHECK_EN.
- Defined: err sets (sticky until rst) on either of:
  - rel_valid to a row with used==0 or cnt==0; cnt and used are left unchanged.
  - in_valid falling in S_STALL.
- Undefined: err is tied to 0 and no checks are done. A release to a row with cnt==0 is ignored (no underflow) in both builds.

Decomposition:
- Package id_alloc_pkg:
  - row_state_t struct {used, id, wr_col, cnt}.
  - ctrl_state_e enum {S_IDLE, S_OUT, S_STALL}.
  - uid_row()/uid_col() field-extract functions.
- One sub-module, id_alloc_lookup: purely combinational match plus first-free priority encoder. Outputs row index and alloc_ok.

Test Plan (MAX_OUTSTANDING=4, ID_WIDTH=4):
1. Reset, then in_id=5 held with out_ready=1 for 3 cycles → out_uid=0x0,0x1,0x2 on consecutive cycles, out_id=5; row0 cnt=3.
2. in_id=5, then 7, then 5 → uids 0x0, 0x4, 0x1; in_ready stays 1 throughout.
3. 4 allocations of id=3, then a 5th with out_ready=1 → FSM S_STALL, in_ready=0. rel_uid=0x0 → next cycle accept, out_uid=0x0 (wr_col wrapped).
4. Fill rows 0–3 with ids 1–4, 4 entries each → full=1. A new id=9 stalls. Release all 4 of row2 → row2 frees and id=9 gets uid 0x8.
5. out_ready=0 for 5 cycles after an accept → out_valid and out_uid hold, in_ready=0; on out_ready=1, a back-to-back accept proceeds.
6. With ERR_CHECK_EN, rel_uid=0xC on an unused row → err=1 next cycle and stays 1. rst → err=0, all rows free.

Source files
------------

// File: rtl/id_alloc_pkg.sv
// rtl/id_alloc_pkg.sv - shared types, widths and uid field helpers for the unique-ID allocator
package id_alloc_pkg;

   // Storage is sized for the widest supported build. Narrower builds zero-extend
   // into these fields, and synthesis trims the constant upper bits.
   localparam int ID_W_MAX  = 16;
   localparam int IDX_W_MAX = 8;
   localparam int UID_W_MAX = 2 * IDX_W_MAX;

   typedef logic [ID_W_MAX-1:0]  id_t;
   typedef logic [IDX_W_MAX-1:0] col_t;
   typedef logic [IDX_W_MAX:0]   cnt_t;
   typedef logic [UID_W_MAX-1:0] uid_t;

   // One table row: the master ID bound to it, next column to hand out,
   // and the number of unique IDs still outstanding.
   typedef struct packed {
      logic used;
      id_t  id;
      col_t wr_col;
      cnt_t cnt;
   } row_state_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_OUT   = 2'd1,
      S_STALL = 2'd2
   } ctrl_state_e;

   // Column field of a {row, col} unique ID whose fields are idx_w bits wide.
   function automatic col_t uid_col(input uid_t uid, input int idx_w);
      uid_t mask;
      mask = UID_W_MAX'((32'd1 << idx_w) - 32'd1);
      return IDX_W_MAX'(uid & mask);
   endfunction

   // Row field of a {row, col} unique ID whose fields are idx_w bits wide.
   function automatic col_t uid_row(input uid_t uid, input int idx_w);
      return uid_col(uid >> idx_w, idx_w);
   endfunction

endpackage

// File: rtl/id_alloc_lookup.sv
// rtl/id_alloc_lookup.sv - combinational row lookup: ID match plus lowest free row
module id_alloc_lookup
   import id_alloc_pkg::*;
#(
   parameter int ID_WIDTH        = 4,
   parameter int MAX_OUTSTANDING = 16,
   localparam int IDX_W          = $clog2(MAX_OUTSTANDING)
) (
   input  row_state_t          rows [MAX_OUTSTANDING],
   input  logic [ID_WIDTH-1:0] in_id,
   output logic [IDX_W-1:0]    row,
   output logic                alloc_ok
);

   localparam cnt_t CNT_FULL = cnt_t'(MAX_OUTSTANDING);

   id_t              key;
   logic             match_hit;
   logic             free_hit;
   logic [IDX_W-1:0] match_row;
   logic [IDX_W-1:0] free_row;

   assign key = id_t'(in_id);

   // Scan high to low so the lowest-index hit is the one that sticks
   always_comb begin
      match_hit = 1'b0;
      match_row = '0;
      free_hit  = 1'b0;
      free_row  = '0;
      for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
         if (rows[i].used && (rows[i].id == key)) begin
            match_hit = 1'b1;
            match_row = IDX_W'(i);
         end
         if (!rows[i].used) begin
            free_hit = 1'b1;
            free_row = IDX_W'(i);
         end
      end
   end

   // A bound ID must stay in its own row to keep order, even when that row is full
   always_comb begin
      row      = free_row;
      alloc_ok = free_hit;
      if (match_hit) begin
         row      = match_row;
         alloc_ok = (rows[match_row].cnt != CNT_FULL);
      end
   end

endmodule

// File: rtl/id_alloc_ctrl.sv
// rtl/id_alloc_ctrl.sv - unique-ID allocate/release controller; ID_ALLOC_ERR_CHECK_EN enables err
module id_alloc_ctrl
   import id_alloc_pkg::*;
#(
   parameter int ID_WIDTH        = 4,
   parameter int MAX_OUTSTANDING = 16,
   localparam int IDX_W          = $clog2(MAX_OUTSTANDING)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [ID_WIDTH-1:0]  in_id,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*IDX_W-1:0]   out_uid,
   output logic [ID_WIDTH-1:0]  out_id,
   input  logic                 rel_valid,
   input  logic [2*IDX_W-1:0]   rel_uid,
   output logic                 full,
   output logic                 err
);

   localparam cnt_t CNT_FULL = cnt_t'(MAX_OUTSTANDING);
   localparam cnt_t CNT_ONE  = cnt_t'(1);
   localparam col_t COL_ONE  = col_t'(1);
   localparam col_t COL_MASK = col_t'(MAX_OUTSTANDING - 1);

   row_state_t       rows     [MAX_OUTSTANDING];
   row_state_t       rows_nxt [MAX_OUTSTANDING];
   ctrl_state_e      state;
   ctrl_state_e      state_nxt;
   logic [IDX_W-1:0] tgt_row;
   logic [IDX_W-1:0] rel_row;
   logic             alloc_ok;
   logic             accept;
   logic             full_nxt;

   id_alloc_lookup #(
      .ID_WIDTH        (ID_WIDTH),
      .MAX_OUTSTANDING (MAX_OUTSTANDING)
   ) u_lookup (
      .rows     (rows),
      .in_id    (in_id),
      .row      (tgt_row),
      .alloc_ok (alloc_ok)
   );

   assign rel_row   = IDX_W'(uid_row(uid_t'(rel_uid), IDX_W));
   assign out_valid = (state == S_OUT);

   // Control state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and request handshake; a new request is taken only when the output slot frees
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      case (state)
         S_IDLE: begin
            in_ready = alloc_ok;
            if (in_valid) begin
               state_nxt = alloc_ok ? S_OUT : S_STALL;
            end
         end
         S_OUT: begin
            in_ready = out_ready && alloc_ok;
            if (out_ready) begin
               if (in_valid && alloc_ok) begin
                  state_nxt = S_OUT;
               end else if (in_valid) begin
                  state_nxt = S_STALL;
               end else begin
                  state_nxt = S_IDLE;
               end
            end
         end
         S_STALL: begin
            in_ready = alloc_ok;
            if (!in_valid) begin
               state_nxt = S_IDLE;
            end else if (alloc_ok) begin
               state_nxt = S_OUT;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
      accept = in_valid && in_ready;
   end

   // Row table update: release first, then allocation, so a same-row pair nets out
   always_comb begin
      rows_nxt = rows;
      if (rel_valid && (rows[rel_row].cnt != '0)) begin
         rows_nxt[rel_row].cnt = rows[rel_row].cnt - CNT_ONE;
         if (rows[rel_row].cnt == CNT_ONE) begin
            rows_nxt[rel_row].used   = 1'b0;
            rows_nxt[rel_row].wr_col = '0;
         end
      end
      if (accept) begin
         rows_nxt[tgt_row].used   = 1'b1;
         rows_nxt[tgt_row].id     = id_t'(in_id);
         rows_nxt[tgt_row].wr_col = (rows[tgt_row].wr_col + COL_ONE) & COL_MASK;
         rows_nxt[tgt_row].cnt    = rows_nxt[tgt_row].cnt + CNT_ONE;
      end
   end

   // Table is full only when every row is bound and saturated
   always_comb begin
      full_nxt = 1'b1;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
         if (!rows_nxt[i].used || (rows_nxt[i].cnt != CNT_FULL)) begin
            full_nxt = 1'b0;
         end
      end
   end

   // Row table and full flag registers
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            rows[i] <= '0;
         end
         full <= 1'b0;
      end else begin
         rows <= rows_nxt;
         full <= full_nxt;
      end
   end

   // Output holding register, loaded on every accepted request
   always_ff @(posedge clk) begin
      if (rst) begin
         out_uid <= '0;
         out_id  <= '0;
      end else if (accept) begin
         out_uid <= {tgt_row, rows[tgt_row].wr_col[IDX_W-1:0]};
         out_id  <= in_id;
      end
   end

`ifdef ID_ALLOC_ERR_CHECK_EN
   // Sticky error: release of an idle row, or a request withdrawn while stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         err <= 1'b0;
      end else if ((rel_valid && (!rows[rel_row].used || (rows[rel_row].cnt == '0))) ||
                   ((state == S_STALL) && !in_valid)) begin
         err <= 1'b1;
      end
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_id_alloc_ctrl.sv
// tb/tb_id_alloc_ctrl.sv - directed self-checking bench for id_alloc_ctrl (4 rows x 4 columns)
module tb_id_alloc_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_id;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_uid;
   logic [3:0] out_id;
   logic       rel_valid;
   logic [3:0] rel_uid;
   logic       full;
   logic       err;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   id_alloc_ctrl #(
      .ID_WIDTH        (4),
      .MAX_OUTSTANDING (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_id     (in_id),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_uid   (out_uid),
      .out_id    (out_id),
      .rel_valid (rel_valid),
      .rel_uid   (rel_uid),
      .full      (full),
      .err       (err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset(input string tag);
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_id     = 4'h0;
      out_ready = 1'b0;
      rel_valid = 1'b0;
      rel_uid   = 4'h0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      check({tag, "_out_valid"}, out_valid, 1'b0);
      check({tag, "_out_uid"}, out_uid, 4'h0);
      check({tag, "_out_id"}, out_id, 4'h0);
      check({tag, "_full"}, full, 1'b0);
      check({tag, "_err"}, err, 1'b0);
      check({tag, "_in_ready"}, in_ready, 1'b1);
   endtask

   initial begin
      // 1: same ID streamed back to back
      do_reset("rst1");
      in_valid = 1'b1; in_id = 4'd5; out_ready = 1'b1;
      #1 check("t1_ready0", in_ready, 1'b1);
      tick();
      check("t1_valid0", out_valid, 1'b1);
      check("t1_uid0", out_uid, 4'h0);
      check("t1_id0", out_id, 4'd5);
      check("t1_ready1", in_ready, 1'b1);
      tick();
      check("t1_uid1", out_uid, 4'h1);
      tick();
      check("t1_uid2", out_uid, 4'h2);
      check("t1_id2", out_id, 4'd5);
      in_valid = 1'b0;
      tick();
      check("t1_drain", out_valid, 1'b0);

      // 2: interleaved IDs land in separate rows
      do_reset("rst2");
      in_valid = 1'b1; in_id = 4'd5; out_ready = 1'b1;
      tick();
      check("t2_uid_a", out_uid, 4'h0);
      in_id = 4'd7;
      #1 check("t2_ready_b", in_ready, 1'b1);
      tick();
      check("t2_uid_b", out_uid, 4'h4);
      check("t2_id_b", out_id, 4'd7);
      in_id = 4'd5;
      #1 check("t2_ready_c", in_ready, 1'b1);
      tick();
      check("t2_uid_c", out_uid, 4'h1);
      check("t2_id_c", out_id, 4'd5);
      in_valid = 1'b0;
      tick();

      // 3: saturated row stalls, release in the same cycle does not unblock it
      do_reset("rst3");
      in_valid = 1'b1; in_id = 4'd3; out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check($sformatf("t3_uid_%0d", k), out_uid, k);
      end
      check("t3_full_row_ready", in_ready, 1'b0);
      tick();
      check("t3_stall_valid", out_valid, 1'b0);
      check("t3_stall_ready", in_ready, 1'b0);
      rel_valid = 1'b1; rel_uid = 4'h0;
      #1 check("t3_rel_same_cycle_ready", in_ready, 1'b0);
      tick();
      rel_valid = 1'b0;
      #1 check("t3_after_rel_ready", in_ready, 1'b1);
      tick();
      check("t3_wrap_valid", out_valid, 1'b1);
      check("t3_wrap_uid", out_uid, 4'h0);
      check("t3_wrap_id", out_id, 4'd3);
      in_valid = 1'b0;
      tick();

      // 4: fill the table, stall a new ID, drain row 2 to free it
      do_reset("rst4");
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < 4; k++) begin
            in_id = 4'(r + 1);
            #1 check($sformatf("t4_ready_%0d_%0d", r, k), in_ready, 1'b1);
            tick();
            check($sformatf("t4_uid_%0d_%0d", r, k), out_uid, r * 4 + k);
         end
      end
      check("t4_full", full, 1'b1);
      in_id = 4'd9;
      #1 check("t4_new_id_ready", in_ready, 1'b0);
      tick();
      check("t4_stall_valid", out_valid, 1'b0);
      for (int k = 0; k < 4; k++) begin
         rel_valid = 1'b1;
         rel_uid   = 4'(8 + k);
         #1 check($sformatf("t4_rel_ready_%0d", k), in_ready, 1'b0);
         tick();
         if (k == 0) begin
            check("t4_full_clear", full, 1'b0);
         end
      end
      rel_valid = 1'b0;
      #1 check("t4_row2_free_ready", in_ready, 1'b1);
      tick();
      check("t4_new_uid", out_uid, 4'h8);
      check("t4_new_id", out_id, 4'd9);
      in_valid = 1'b0;
      tick();

      // 5: downstream backpressure holds the result
      do_reset("rst5");
      in_valid = 1'b1; in_id = 4'd6; out_ready = 1'b0;
      tick();
      for (int c = 0; c < 5; c++) begin
         check($sformatf("t5_hold_valid_%0d", c), out_valid, 1'b1);
         check($sformatf("t5_hold_uid_%0d", c), out_uid, 4'h0);
         check($sformatf("t5_hold_ready_%0d", c), in_ready, 1'b0);
         tick();
      end
      out_ready = 1'b1;
      #1 check("t5_release_ready", in_ready, 1'b1);
      tick();
      check("t5_b2b_valid", out_valid, 1'b1);
      check("t5_b2b_uid", out_uid, 4'h1);
      in_valid = 1'b0;
      tick();
      check("t5_drain", out_valid, 1'b0);

      // 6: release to an idle row
      do_reset("rst6");
      rel_valid = 1'b1; rel_uid = 4'hC;
      tick();
      rel_valid = 1'b0;
`ifdef ID_ALLOC_ERR_CHECK_EN
      check("t6_err_set", err, 1'b1);
      tick();
      check("t6_err_sticky", err, 1'b1);
`else
      check("t6_err_tied", err, 1'b0);
      tick();
      check("t6_err_tied_later", err, 1'b0);
`endif
      do_reset("rst6b");
      in_valid = 1'b1; in_id = 4'd2; out_ready = 1'b1;
      tick();
      check("t6_post_reset_uid", out_uid, 4'h0);
      in_valid = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
